// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide
// share one 2W-bit accumulator and one adder/subtractor; holds HI/LO.
module mdu
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic [2:0]            i_Op,
  input  logic [DATA_WIDTH-1:0] i_Data_1,
  input  logic [DATA_WIDTH-1:0] i_Data_2,
  input  logic                  i_Flush,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [DATA_WIDTH-1:0] o_HI,
  output logic [DATA_WIDTH-1:0] o_LO
);

  localparam int W         = DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH);

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  mdu_state_e           state_q, state_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         opnd_q, opnd_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic                 signed_op, a_neg, b_neg;
  logic [W:0]           add_a, add_b;
  logic [W+1:0]         alu;
  logic [2*W-1:0]       prod;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    signed_op = (i_Op == MDU_MULT) || (i_Op == MDU_DIV);
    a_neg     = signed_op & i_Data_1[W-1];
    b_neg     = signed_op & i_Data_2[W-1];
    prod      = neg_res_q ? -acc_q : acc_q;
    // Divide feeds the shifted partial remainder (W+1 bits); multiply feeds the high half.
    add_a     = is_div_q ? acc_q[2*W-1:W-1] : {1'b0, acc_q[2*W-1:W]};
    add_b     = {1'b0, opnd_q};
    alu       = is_div_q ? ({1'b0, add_a} - {1'b0, add_b}) : ({1'b0, add_a} + {1'b0, add_b});

    case (state_q)
      ST_IDLE: begin
        if (i_Start && !i_Flush) begin
          case (i_Op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              acc_d     = {{W{1'b0}}, cond_neg(i_Data_1, a_neg)};
              opnd_d    = cond_neg(i_Data_2, b_neg);
              is_div_d  = i_Op[1];
              // A zero divisor leaves the all-ones quotient unnegated.
              neg_res_d = (a_neg ^ b_neg) & (i_Data_2 != '0);
              neg_rem_d = a_neg;
              cnt_d     = '0;
              state_d   = ST_RUN;
            end
            MDU_MTHI: hi_d = i_Data_1;
            MDU_MTLO: lo_d = i_Data_1;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (i_Flush) begin
          state_d = ST_IDLE;
        end else begin
          if (is_div_q) begin
            if (!alu[W+1]) acc_d = {alu[W-1:0], acc_q[W-2:0], 1'b1};
            else           acc_d = {acc_q[2*W-2:0], 1'b0};
          end else begin
            if (acc_q[0]) acc_d = {alu[W:0], acc_q[W-1:1]};
            else          acc_d = {1'b0, acc_q[2*W-1:1]};
          end
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(W - 1)) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        if (!i_Flush) begin
          // With a zero divisor the remainder has shifted in the whole dividend.
          if (is_div_q) begin
            lo_d = cond_neg(acc_q[W-1:0], neg_res_q);
            hi_d = cond_neg(acc_q[2*W-1:W], neg_rem_q);
          end else begin
            {hi_d, lo_d} = prod;
          end
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    acc_q     <= acc_d;
    opnd_q    <= opnd_d;
    cnt_q     <= cnt_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
  end

  assign o_Busy = busy_q;
  assign o_Done = done_q;
  assign o_HI   = hi_q;
  assign o_LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Randomised and directed bench for mdu against an arithmetic reference model.
module tb_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] d1, d2;
  logic         flush;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mdu #(.DATA_WIDTH(W)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start), .i_Op(op),
    .i_Data_1(d1), .i_Data_2(d2), .i_Flush(flush),
    .o_Busy(busy), .o_Done(done), .o_HI(hi), .o_LO(lo)
  );

  always #5 clk = ~clk;

  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, p;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0;
    el = '0;
    case (o)
      3'b000: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      3'b001: begin up = {32'b0, a} * {32'b0, b}; eh = up[63:32]; el = up[31:0]; end
      3'b010: begin
        if (b == 0) begin eh = a; el = 32'hFFFFFFFF; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin eh = 0; el = 32'h80000000; end
        else begin p = sa / sb; el = p[31:0]; p = sa % sb; eh = p[31:0]; end
      end
      3'b011: begin
        if (b == 0) begin eh = a; el = 32'hFFFFFFFF; end
        else begin el = a / b; eh = a % b; end
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Enter and leave #1 after a rising edge; issues one op and checks latency and result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    logic [31:0] eh, el;
    int cyc;
    bit busy_drop;
    model(o, a, b, eh, el);
    start = 1'b1; op = o; d1 = a; d2 = b;
    @(posedge clk); #1;
    start = 1'b0; d1 = $urandom; d2 = $urandom;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_at_start got %b want 1", name, busy); end
    cyc = 0;
    busy_drop = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) busy_drop = 1;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != W + 1 || busy_drop) begin
      errors++; $display("FAIL %s latency got %0d (busy_drop=%0d) want %0d", name, cyc, busy_drop, W + 1);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      errors++;
      $display("FAIL %s op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h", name, o, a, b, hi, lo, eh, el);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", name, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; op = 0; d1 = 0; d2 = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
      errors++; $display("FAIL reset hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_single_pulse got %b want 0", done); end
    run_op(3'b000, 32'hFFFFFFFD, 32'd5, "mult_neg3x5");
    run_op(3'b001, 32'hFFFFFFFD, 32'd5, "multu_fffd_x5");
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, "div_neg7_2");
    run_op(3'b011, 32'd7, 32'd2, "divu_7_2");
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(3'b011, 32'h1234, 32'd0, "divu_by0");
    run_op(3'b010, 32'hFFFFFFF9, 32'd0, "div_neg_by0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 3)), pick(), pick(), "random");
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_op(3'($urandom_range(0, 3)), $urandom, $urandom, "b2b");
  endtask

  task automatic test_flush_and_ignore();
    logic [31:0] lo_prev;
    bit saw_done;
    lo_prev = lo;
    start = 1'b1; op = 3'b100; d1 = 32'hAAAA0000;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (hi !== 32'hAAAA0000 || lo !== lo_prev || busy !== 0 || done !== 0) begin
      errors++; $display("FAIL mthi hi=%h lo=%h busy=%b done=%b want hi=aaaa0000 lo=%h 0 0", hi, lo, busy, done, lo_prev);
    end
    start = 1'b1; op = 3'b000; d1 = 32'd7; d2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (c == 3 || c == 6) begin start = 1'b1; op = 3'b100; d1 = 32'h11111111; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL flush_no_done got done pulse want none"); end
    checks++;
    if (hi !== 32'hAAAA0000 || lo !== lo_prev) begin
      errors++; $display("FAIL flush_keep hi=%h lo=%h want hi=aaaa0000 lo=%h", hi, lo, lo_prev);
    end
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; op = (k == 0) ? 3'b110 : 3'b111; d1 = 32'h5555AAAA; d2 = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 0 || hi !== 32'hAAAA0000 || lo !== lo_prev) begin
        errors++; $display("FAIL illegal_op%0d busy=%b hi=%h lo=%h want 0 aaaa0000 %h", k, busy, hi, lo, lo_prev);
      end
    end
    start = 1'b1; flush = 1'b1; op = 3'b101; d1 = 32'h0BADF00D;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (lo !== lo_prev || busy !== 0) begin
      errors++; $display("FAIL flush_idle_priority lo=%h busy=%b want lo=%h busy=0", lo, busy, lo_prev);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = 3'b010; d1 = 32'd1000; d2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
      errors++; $display("FAIL async_reset hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 3'b101; d1 = 32'h5;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (lo !== 32'h5 || hi !== 0 || busy !== 0) begin
      errors++; $display("FAIL mtlo_after_reset lo=%h hi=%h busy=%b want lo=5 hi=0 busy=0", lo, hi, busy);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (done !== 0 || lo !== 32'h5) begin
      errors++; $display("FAIL reset_kills_op done=%b lo=%h want 0 5", done, lo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush_and_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
